lcd_dma_axi_reader: RTL and testbench

Single-clock AXI4 read master sitting directly upstream of the LCD DMA FIFO. It accepts one-cycle burst requests on the DMA request interface (`DMA_START`, `DMA_RD_ADDR`, `DMA_READY`) and turns each into one fixed-length AXI4 INCR read burst. Returned beats go back to the FIFO as `DMA_RD_DATA` / `DMA_RD_DATA_VALID`. It also flags AXI response and burst-length errors with sticky bits.

---
 rtl/lcd_dma_axi_reader.sv | 147 ++++++++++++++
 tb/tb_lcd_dma_axi_reader.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_dma_axi_reader.sv
// AXI4 read master for the LCD DMA FIFO: turns each one-cycle request into a
// fixed-length INCR burst and returns the beats to the FIFO, with sticky error flags.
module lcd_dma_axi_reader #(
    parameter int         BURST_SIZE  = 8,
    parameter logic [3:0] ARCACHE_VAL = 4'b0011
) (
    input  logic        CLK,
    input  logic        RESETN,
    input  logic [29:0] DMA_RD_ADDR,
    input  logic        DMA_START,
    output logic        DMA_READY,
    output logic [31:0] DMA_RD_DATA,
    output logic        DMA_RD_DATA_VALID,
    output logic [31:0] M_AXI_ARADDR,
    output logic [7:0]  M_AXI_ARLEN,
    output logic [2:0]  M_AXI_ARSIZE,
    output logic [1:0]  M_AXI_ARBURST,
    output logic [3:0]  M_AXI_ARCACHE,
    output logic [2:0]  M_AXI_ARPROT,
    output logic        M_AXI_ARVALID,
    input  logic        M_AXI_ARREADY,
    input  logic [31:0] M_AXI_RDATA,
    input  logic [1:0]  M_AXI_RRESP,
    input  logic        M_AXI_RLAST,
    input  logic        M_AXI_RVALID,
    output logic        M_AXI_RREADY,
    output logic        ERR_RESP,
    output logic        ERR_LAST,
    input  logic        ERR_CLEAR
);

    localparam logic [8:0] LAST_BEAT = 9'(BURST_SIZE - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [8:0]  r_beat_cnt;
    logic        r_dma_ready;
    logic        r_arvalid;
    logic        r_rready;
    logic [31:0] r_araddr;
    logic [31:0] r_rd_data;
    logic        r_rd_data_valid;
    logic        r_err_resp;
    logic        r_err_last;
    logic        w_rbeat;
    logic        w_last_beat;
    logic        w_err_resp_set;
    logic        w_err_last_set;

    assign M_AXI_ARLEN       = 8'(BURST_SIZE - 1);
    assign M_AXI_ARSIZE      = 3'b010;
    assign M_AXI_ARBURST     = 2'b01;
    assign M_AXI_ARCACHE     = ARCACHE_VAL;
    assign M_AXI_ARPROT      = 3'b000;
    assign M_AXI_ARADDR      = r_araddr;
    assign M_AXI_ARVALID     = r_arvalid;
    assign M_AXI_RREADY      = r_rready;
    assign DMA_READY         = r_dma_ready;
    assign DMA_RD_DATA       = r_rd_data;
    assign DMA_RD_DATA_VALID = r_rd_data_valid;
    assign ERR_RESP          = r_err_resp;
    assign ERR_LAST          = r_err_last;

    // Beat qualification and error detection; RLAST is only checked, never used to end a burst.
    always_comb begin
        w_rbeat        = (r_state == ST_DATA) && r_rready && M_AXI_RVALID;
        w_last_beat    = (r_beat_cnt == LAST_BEAT);
        w_err_resp_set = w_rbeat && (M_AXI_RRESP != 2'b00);
        if (w_last_beat) begin
            w_err_last_set = w_rbeat && !M_AXI_RLAST;
        end else begin
            w_err_last_set = w_rbeat && M_AXI_RLAST;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (DMA_START) begin
                    w_state_nxt = ST_ADDR;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ADDR: begin
                if (M_AXI_ARREADY) begin
                    w_state_nxt = ST_DATA;
                end else begin
                    w_state_nxt = ST_ADDR;
                end
            end
            ST_DATA: begin
                if (w_rbeat && w_last_beat) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_DATA;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State register and registered outputs, derived from the next state so they lead by no cycle.
    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            r_state         <= ST_IDLE;
            r_beat_cnt      <= 9'd0;
            r_dma_ready     <= 1'b0;
            r_arvalid       <= 1'b0;
            r_rready        <= 1'b0;
            r_araddr        <= 32'd0;
            r_rd_data       <= 32'd0;
            r_rd_data_valid <= 1'b0;
            r_err_resp      <= 1'b0;
            r_err_last      <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_dma_ready     <= (w_state_nxt == ST_IDLE);
            r_arvalid       <= (w_state_nxt == ST_ADDR);
            r_rready        <= (w_state_nxt == ST_DATA);
            r_rd_data_valid <= w_rbeat;
            if ((r_state == ST_IDLE) && DMA_START) begin
                r_araddr <= {DMA_RD_ADDR, 2'b00};
            end
            if ((r_state == ST_ADDR) && M_AXI_ARREADY) begin
                r_beat_cnt <= 9'd0;
            end else if (w_rbeat) begin
                r_beat_cnt <= r_beat_cnt + 9'd1;
            end
            if (w_rbeat) begin
                r_rd_data <= M_AXI_RDATA;
            end
            // A new error in the same cycle as a clear keeps the flag set.
            r_err_resp <= w_err_resp_set | (r_err_resp & ~ERR_CLEAR);
            r_err_last <= w_err_last_set | (r_err_last & ~ERR_CLEAR);
        end
    end

endmodule

// File: tb/tb_lcd_dma_axi_reader.sv
// Directed bench for lcd_dma_axi_reader: drives the DMA side and plays the AXI slave,
// checking addresses, returned words, timing and error flags against hand-derived values.
module tb_lcd_dma_axi_reader;

    localparam int N = 8;

    logic        clk = 1'b0;
    logic        resetn;
    logic [29:0] dma_rd_addr;
    logic        dma_start;
    logic        dma_ready;
    logic [31:0] dma_rd_data;
    logic        dma_rd_data_valid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    logic        err_resp;
    logic        err_last;
    logic        err_clear;

    logic [29:0] b_addr;
    logic        b_start;
    logic        b_ready;
    logic [31:0] b_data;
    logic        b_valid;
    logic [31:0] b_araddr;
    logic [7:0]  b_arlen;
    logic [2:0]  b_arsize;
    logic [1:0]  b_arburst;
    logic [3:0]  b_arcache;
    logic [2:0]  b_arprot;
    logic        b_arvalid;
    logic        b_arready;
    logic [31:0] b_rdata;
    logic        b_rlast;
    logic        b_rvalid;
    logic        b_rready;
    logic        b_err_resp;
    logic        b_err_last;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    lcd_dma_axi_reader #(.BURST_SIZE(N), .ARCACHE_VAL(4'b0011)) u_dut (
        .CLK(clk), .RESETN(resetn),
        .DMA_RD_ADDR(dma_rd_addr), .DMA_START(dma_start), .DMA_READY(dma_ready),
        .DMA_RD_DATA(dma_rd_data), .DMA_RD_DATA_VALID(dma_rd_data_valid),
        .M_AXI_ARADDR(araddr), .M_AXI_ARLEN(arlen), .M_AXI_ARSIZE(arsize),
        .M_AXI_ARBURST(arburst), .M_AXI_ARCACHE(arcache), .M_AXI_ARPROT(arprot),
        .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
        .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RLAST(rlast),
        .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready),
        .ERR_RESP(err_resp), .ERR_LAST(err_last), .ERR_CLEAR(err_clear)
    );

    lcd_dma_axi_reader #(.BURST_SIZE(256), .ARCACHE_VAL(4'b0011)) u_dut_256 (
        .CLK(clk), .RESETN(resetn),
        .DMA_RD_ADDR(b_addr), .DMA_START(b_start), .DMA_READY(b_ready),
        .DMA_RD_DATA(b_data), .DMA_RD_DATA_VALID(b_valid),
        .M_AXI_ARADDR(b_araddr), .M_AXI_ARLEN(b_arlen), .M_AXI_ARSIZE(b_arsize),
        .M_AXI_ARBURST(b_arburst), .M_AXI_ARCACHE(b_arcache), .M_AXI_ARPROT(b_arprot),
        .M_AXI_ARVALID(b_arvalid), .M_AXI_ARREADY(b_arready),
        .M_AXI_RDATA(b_rdata), .M_AXI_RRESP(2'b00), .M_AXI_RLAST(b_rlast),
        .M_AXI_RVALID(b_rvalid), .M_AXI_RREADY(b_rready),
        .ERR_RESP(b_err_resp), .ERR_LAST(b_err_last), .ERR_CLEAR(1'b0)
    );

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One burst, stepped at posedge+1. Starts at a step where DMA_READY is expected high
    // and returns at the step where DMA_READY comes back, so a caller can chain a START.
    task automatic run_burst(input logic [29:0] addr, input logic [31:0] dbase,
                             input int ar_wait, input bit rand_rv, input int err_beat,
                             input int last_at, input bit spam, input bit chk_time,
                             input int rst_at, input bit exp_eresp, input bit exp_elast);
        int  c = 0;
        int  sent = 0;
        int  got = 0;
        int  ar_cnt = 0;
        int  ar_hs = 0;
        bit  done = 1'b0;
        bit  rst_hit = 1'b0;
        chk_val("ready_before_start", 32'(dma_ready), 32'd1);
        dma_start   = 1'b1;
        dma_rd_addr = addr;
        while (!done && c < 600) begin
            @(posedge clk);
            #1;
            c++;
            dma_start = 1'b0;
            if (rst_hit) begin
                chk_val("rst_ready", 32'(dma_ready), 32'd0);
                chk_val("rst_arvalid", 32'(arvalid), 32'd0);
                chk_val("rst_rready", 32'(rready), 32'd0);
                chk_val("rst_valid", 32'(dma_rd_data_valid), 32'd0);
                chk_val("rst_data", dma_rd_data, 32'd0);
                chk_val("rst_araddr", araddr, 32'd0);
                chk_val("rst_errs", {30'd0, err_resp, err_last}, 32'd0);
                resetn = 1'b1;
                done   = 1'b1;
            end else begin
                if (dma_rd_data_valid) begin
                    chk_val("beat_data", dma_rd_data, dbase + 32'(got));
                    got++;
                end
                if (chk_time && c == 1) begin
                    chk_val("t1_arvalid", 32'(arvalid), 32'd1);
                    chk_val("t1_ready", 32'(dma_ready), 32'd0);
                end
                if (arvalid) begin
                    chk_val("araddr_stable", araddr, {addr, 2'b00});
                end
                if (dma_ready) begin
                    done = 1'b1;
                    chk_val("last_strobe_with_ready", 32'(dma_rd_data_valid), 32'd1);
                    arready = 1'b0;
                    rvalid  = 1'b0;
                    rlast   = 1'b0;
                    rresp   = 2'b00;
                end else begin
                    arready = arvalid && (ar_cnt >= ar_wait);
                    if (arvalid) ar_cnt++;
                    if (arvalid && arready) ar_hs++;
                    if (rready && sent < N) begin
                        rvalid = rand_rv ? 1'($urandom_range(0, 1)) : 1'b1;
                        rdata  = dbase + 32'(sent);
                        rresp  = (sent == err_beat) ? 2'b10 : 2'b00;
                        rlast  = (sent == last_at);
                    end else begin
                        rvalid = 1'b0;
                        rlast  = 1'b0;
                        rresp  = 2'b00;
                    end
                    if (rvalid && rready) sent++;
                    if (rst_at >= 0 && sent == rst_at) begin
                        resetn  = 1'b0;
                        rst_hit = 1'b1;
                        arready = 1'b0;
                        rvalid  = 1'b0;
                    end
                    if (spam && (c % 3) == 0) dma_start = 1'b1;
                end
            end
        end
        chk_val("burst_done", 32'(done), 32'd1);
        if (rst_at < 0) begin
            chk_val("beat_count", 32'(got), 32'(N));
            chk_val("ar_handshakes", 32'(ar_hs), 32'd1);
            chk_val("err_resp", 32'(err_resp), 32'(exp_eresp));
            chk_val("err_last", 32'(err_last), 32'(exp_elast));
            if (chk_time) chk_val("ready_latency", 32'(c), 32'(N + 2));
        end
    endtask

    initial begin
        int c;
        int got;
        int sent;
        bit done;
        resetn = 1'b0; dma_start = 1'b0; dma_rd_addr = 30'd0; err_clear = 1'b0;
        arready = 1'b0; rdata = 32'd0; rresp = 2'b00; rlast = 1'b0; rvalid = 1'b0;
        b_addr = 30'd0; b_start = 1'b0; b_arready = 1'b0; b_rdata = 32'd0;
        b_rlast = 1'b0; b_rvalid = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk_val("reset_ready", 32'(dma_ready), 32'd0);
        chk_val("reset_arvalid", 32'(arvalid), 32'd0);
        chk_val("reset_araddr", araddr, 32'd0);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        chk_val("ready_after_release", 32'(dma_ready), 32'd1);
        chk_val("arlen", 32'(arlen), 32'd7);
        chk_val("arsize", 32'(arsize), 32'd2);
        chk_val("arburst", 32'(arburst), 32'd1);
        chk_val("arcache", 32'(arcache), 32'd3);
        chk_val("arprot", 32'(arprot), 32'd0);

        // Basic burst at word address 0x100 -> byte 0x400, data 0..7, exact timing.
        run_burst(30'h0000_0100, 32'd0, 0, 1'b0, -1, N - 1, 1'b0, 1'b1, -1, 1'b0, 1'b0);

        // Back-to-back: first burst with backpressure and START spam, second START on first ready cycle.
        run_burst(30'h0000_0200, 32'h1000, 5, 1'b1, -1, N - 1, 1'b1, 1'b0, -1, 1'b0, 1'b0);
        run_burst(30'h3FFF_FFF8, 32'h2000, 0, 1'b1, -1, N - 1, 1'b0, 1'b0, -1, 1'b0, 1'b0);

        // Error burst: SLVERR on beat 3, RLAST early on beat 6 and missing on beat 7.
        run_burst(30'h0000_0300, 32'h3000, 1, 1'b0, 3, 6, 1'b0, 1'b0, -1, 1'b1, 1'b1);
        err_clear = 1'b1;
        @(posedge clk);
        #1;
        err_clear = 1'b0;
        chk_val("clear_err_resp", 32'(err_resp), 32'd0);
        chk_val("clear_err_last", 32'(err_last), 32'd0);

        // Reset after 4 beats, then a fresh burst.
        run_burst(30'h0000_0400, 32'h4000, 0, 1'b0, -1, N - 1, 1'b0, 1'b0, 4, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        run_burst(30'h0000_0500, 32'h5000, 0, 1'b0, -1, N - 1, 1'b0, 1'b1, -1, 1'b0, 1'b0);

        // BURST_SIZE=256 instance, zero wait states.
        @(posedge clk);
        #1;
        chk_val("b256_ready", 32'(b_ready), 32'd1);
        chk_val("b256_arlen", 32'(b_arlen), 32'd255);
        b_start = 1'b1;
        b_addr  = 30'h0000_0200;
        c = 0; got = 0; sent = 0; done = 1'b0;
        while (!done && c < 400) begin
            @(posedge clk);
            #1;
            c++;
            b_start = 1'b0;
            if (b_valid) begin
                chk_val("b256_data", b_data, 32'(got));
                got++;
            end
            if (b_arvalid) chk_val("b256_araddr", b_araddr, 32'h0000_0800);
            if (b_ready) done = 1'b1;
            b_arready = b_arvalid;
            b_rvalid  = b_rready && (sent < 256);
            b_rdata   = 32'(sent);
            b_rlast   = (sent == 255);
            if (b_rvalid) sent++;
        end
        chk_val("b256_done", 32'(done), 32'd1);
        chk_val("b256_count", 32'(got), 32'd256);
        chk_val("b256_latency", 32'(c), 32'd258);
        chk_val("b256_err_last", 32'(b_err_last), 32'd0);
        chk_val("b256_err_resp", 32'(b_err_resp), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
